// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the PWM duty/threshold path.
package pwm_pkg;
  function automatic int roundup8(input int n);
    return ((n + 7) / 8) * 8;
  endfunction

  localparam logic [7:0] CMD_COMMIT = 8'hFF;

  typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, XFER = 2'd2} state_t;

  // Widths for the default 16-bit duty configuration.
  localparam int pwm_bits  = 4;
  localparam int spi_width = 8 + roundup8(16);
endpackage

// File: rtl/plane_transpose.sv
// Picks bit `sel` out of every channel's duty value to form one bit-plane word.
module plane_transpose #(
  parameter int pwm_width = 16,
  parameter int num_pwm   = 12,
  parameter int pwm_bits  = 4
) (
  input  logic [num_pwm-1:0][pwm_width-1:0] src,
  input  logic [pwm_bits-1:0]               sel,
  output logic [num_pwm-1:0]                plane
);
  for (genvar c = 0; c < num_pwm; c++) begin : g_ch
    assign plane[c] = src[c][sel];
  end
endmodule

// File: rtl/duty_plane_loader.sv
// Stages per-channel duties from SPI, snapshots on commit and writes the snapshot
// to thresmem as bit planes at the next frame boundary so no frame is torn.
module duty_plane_loader #(
  parameter int  pwm_width = 16,
  parameter int  num_pwm   = 12,
  localparam int spi_width = 8 + pwm_pkg::roundup8(pwm_width),
  localparam int pwm_bits  = (pwm_width > 1) ? $clog2(pwm_width) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  input  logic [spi_width-1:0] cmd_data,
  input  logic                 frame_sync,
  output logic                 mem_we,
  output logic [pwm_bits-1:0]  mem_waddr,
  output logic [num_pwm-1:0]   mem_wdata,
  output logic                 busy,
  output logic                 cmd_err
);
  import pwm_pkg::*;

  localparam logic [pwm_bits-1:0] LAST = pwm_bits'(pwm_width - 1);

  state_t                           state, state_next;
  logic [num_pwm-1:0][pwm_width-1:0] staging, snapshot, tp_src;
  logic [pwm_bits-1:0]              p, plane_sel;
  logic                             commit_req;
  logic [7:0]                       cmd_id;
  logic [pwm_width-1:0]             cmd_duty;
  logic                             is_stage, is_commit, is_bad;
  logic                             snap_load, req_set, req_clr, we_next, src_staging;
  logic [num_pwm-1:0]               plane_word;

  assign cmd_id    = cmd_data[spi_width-1 -: 8];
  assign cmd_duty  = cmd_data[pwm_width-1:0];
  assign is_commit = cmd_valid && (cmd_id == CMD_COMMIT);
  assign is_stage  = cmd_valid && (int'(cmd_id) < num_pwm);
  assign is_bad    = cmd_valid && !is_stage && !is_commit;

  // A commit landing on the same cycle as frame_sync must feed plane 0 from
  // staging, since the snapshot only picks up that value at this edge.
  assign tp_src = src_staging ? staging : snapshot;

  plane_transpose #(
    .pwm_width(pwm_width),
    .num_pwm  (num_pwm),
    .pwm_bits (pwm_bits)
  ) u_transpose (
    .src  (tp_src),
    .sel  (plane_sel),
    .plane(plane_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // p always names the plane currently on the output registers.
  always_comb begin
    state_next  = state;
    snap_load   = 1'b0;
    req_set     = 1'b0;
    req_clr     = 1'b0;
    we_next     = 1'b0;
    plane_sel   = '0;
    src_staging = 1'b0;
    case (state)
      IDLE: begin
        if (is_commit) begin
          snap_load  = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (is_commit) snap_load = 1'b1;
        if (frame_sync) begin
          state_next  = XFER;
          we_next     = 1'b1;
          src_staging = is_commit;
        end
      end
      XFER: begin
        if (p == LAST) begin
          if (commit_req || is_commit) begin
            snap_load  = 1'b1;
            req_clr    = 1'b1;
            state_next = PENDING;
          end else begin
            state_next = IDLE;
          end
        end else begin
          we_next   = 1'b1;
          plane_sel = p + pwm_bits'(1);
          req_set   = is_commit;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging    <= '0;
      snapshot   <= '0;
      commit_req <= 1'b0;
      p          <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      for (int c = 0; c < num_pwm; c++)
        if (is_stage && int'(cmd_id) == c) staging[c] <= cmd_duty;
      if (snap_load) snapshot <= staging;
      if (req_clr)      commit_req <= 1'b0;
      else if (req_set) commit_req <= 1'b1;
      p         <= plane_sel;
      mem_we    <= we_next;
      mem_wdata <= we_next ? plane_word : '0;
      busy      <= (state_next != IDLE);
      cmd_err   <= is_bad;
    end
  end

  assign mem_waddr = p;
endmodule

// File: doc/duty_plane_loader.md
# duty_plane_loader

Converts per-channel duty commands from the SPI slave into bit-plane writes for the threshold memory.
- Sits between `spi_slave` and `thresmem`, replacing the direct SPI-to-memory path.
- Holds a staging copy of every channel's duty value and snapshots it on a commit command.
- At the next PWM frame boundary, transposes the snapshot into `pwm_width` bit-plane words and writes them to `thresmem` in consecutive cycles, so the PWM never displays a half-updated set of channels.

## Interface
- `pwm_width`, 16, duty bits per channel; also the number of bit planes.
- `num_pwm`, 12, number of PWM channels.
- `spi_width`, 8 + roundup8(`pwm_width`), SPI word width; derived, do not override.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: single-cycle strobe; `cmd_data` is valid (from `spi_slave` data_ready).
- `cmd_data` in `spi_width`: [spi_width-1 -: 8] is the channel id; [pwm_width-1:0] is the duty.
- `frame_sync` in 1: single-cycle pulse from `pwm` at the end of each full bit-plane frame.
- `mem_we` out 1: thresmem write enable.
- `mem_waddr` out clog2(`pwm_width`): bit-plane index.
- `mem_wdata` out `num_pwm`: plane word. Bit c is bit p of channel c's duty, where p = `mem_waddr`.
- `busy` out 1: a commit is pending or a transfer is in progress.
- `cmd_err` out 1: one-cycle pulse when a command is dropped.

## Operation
- Registers:
  - staging[`num_pwm`][`pwm_width`] and snapshot[`num_pwm`][`pwm_width`], both cleared by reset.
  - 2-bit state and plane counter p.
  - commit_req flag.
- Command decode, on `cmd_valid`:
  - id < `num_pwm`: staging[id] ← duty. Staging writes are legal in every state.
  - id == 8'hFF: commit (see below).
  - Any other id: word dropped, `cmd_err` = 1 next cycle, no other effect.
- Commit in IDLE or PENDING: snapshot ← staging, then state = PENDING. A re-commit in PENDING refreshes the snapshot.
- Commit in XFER: commit_req ← 1. The snapshot is not touched during XFER.
- State machine:
  - IDLE → PENDING on commit.
  - PENDING → XFER on `frame_sync`; p ← 0.
  - XFER: one plane written per cycle; p increments.
  - At p == `pwm_width`-1, exit XFER. If commit_req is set: snapshot ← staging, clear commit_req, go to PENDING. Otherwise go to IDLE.
- `frame_sync` in IDLE or XFER is ignored.
- Commit and `frame_sync` in the same cycle while PENDING: the snapshot refreshes and XFER starts the next cycle using the refreshed snapshot.
- Commit and final XFER cycle together: commit_req is set and honoured in the same exit transition, so no commit is lost.
- Width rules: `mem_waddr` wraps naturally; `pwm_width` must be a power of two.

## Timing
- Reset: `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `busy`=0, `cmd_err`=0. State IDLE, all arrays 0.
- All outputs are registered.
- `frame_sync` sampled in PENDING at cycle t: `mem_we`=1 in cycles t+1 .. t+`pwm_width`, with `mem_waddr` = 0,1,…,`pwm_width`-1.
- `mem_we` is low at t+`pwm_width`+1.
- `busy` rises the cycle after the commit is sampled. It falls the cycle after the last write, unless re-pending.
- `cmd_err` latency: 1 cycle.
- Integration constraint: `pwm` must not read plane 0 sooner than `pwm_width`+1 cycles after `frame_sync`.
- Reset asserted mid-transfer: writes stop immediately and the partial plane set stays in thresmem. Software must re-commit.

## Structure
- Shared package `pwm_pkg`:
  - `roundup8` function.
  - CMD_COMMIT = 8'hFF.
  - State enum {IDLE, PENDING, XFER}.
  - Derived widths: pwm_bits, spi_width.
- One sub-module, `plane_transpose`: combinational selection of bit p from each snapshot entry into a `num_pwm` word. The register on its output belongs to the parent.
- `top` wiring: `spi_slave` → `duty_plane_loader` → `thresmem` write port. `frame_sync` comes from `pwm`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. All outputs are 0, no write for 50 cycles without a commit.
- Basic transfer:
  - Stimulus: ch0=16'h0001, ch11=16'h8000, commit, `frame_sync`.
  - Expected: exactly 16 writes in consecutive cycles, addr 0..15.
  - Plane 0 = 12'h001, plane 15 = 12'h800, every other plane = 12'h000.
- Tear-free update:
  - Stimulus: commit ch3=16'hFFFF, then write ch3=16'h0000 before `frame_sync`.
  - Expected: every plane has bit 3 set.
  - A second commit plus `frame_sync` then gives bit 3 clear on all planes.
- Commit during XFER: issue a commit at plane 7. Expected: the transfer finishes unchanged, `busy` stays high, and the next `frame_sync` produces a second 16-write burst with the new data.
- Bad id: send id 8'h0C, then 8'h80. Expected: two `cmd_err` pulses, staging unchanged, no writes.
- Reset mid-XFER: assert `rst_n` at plane 5. Expected: `mem_we` drops asynchronously, state returns to IDLE, and `busy` is 0.
